// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the input conditioner: FSM encoding and glitch counter sizing.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    IdleLow  = 2'd0,
    WaitHigh = 2'd1,
    IdleHigh = 2'd2,
    WaitLow  = 2'd3
  } state_e;

  localparam int unsigned GlitchCntW = 8;
  localparam logic [GlitchCntW-1:0] GlitchSat = 8'd255;

endpackage

// File: rtl/input_conditioner_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input; clears to 0 on reset.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a raw input into a clean level with rise/fall pulses.
// Optional aborted-transition counter enabled by INPUT_CONDITIONER_GLITCH_CNT_EN.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  raw_in,
  output logic                  level,
  output logic                  rise,
  output logic                  fall,
  output logic [GlitchCntW-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       s;
  state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_chain (
    .clk(clk),
    .rst(rst),
    .d  (raw_in),
    .q  (s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IdleLow: begin
        if (s) begin
          state_d = WaitHigh;
          cnt_d   = CNT_W'(1);
        end
      end
      WaitHigh: begin
        if (s) begin
          if (cnt_q == CntLast) begin
            state_d = IdleHigh;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = IdleLow;
          cnt_d   = '0;
        end
      end
      IdleHigh: begin
        if (!s) begin
          state_d = WaitLow;
          cnt_d   = CNT_W'(1);
        end
      end
      WaitLow: begin
        if (!s) begin
          if (cnt_q == CntLast) begin
            state_d = IdleLow;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = IdleHigh;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IdleLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
  logic                  glitch_evt;
  logic [GlitchCntW-1:0] glitch_q;

  // An abort is any WAIT state seeing the opposite synchronized value.
  assign glitch_evt = ((state_q == WaitHigh) && !s) || ((state_q == WaitLow) && s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_q <= '0;
    end else if (glitch_evt && (glitch_q != GlitchSat)) begin
      glitch_q <= glitch_q + GlitchCntW'(1);
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner at default parameters, 5 ns clock.
`timescale 1ns/100ps
module tb_input_conditioner;

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
  localparam bit GlitchEn = 1'b1;
`else
  localparam bit GlitchEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       raw_in;
  logic       level;
  logic       rise;
  logic       fall;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  input_conditioner dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .glitch_cnt(glitch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #2.5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic lv, input logic rs, input logic fl);
    check({tag, ".level"}, {7'd0, level}, {7'd0, lv});
    check({tag, ".rise"}, {7'd0, rise}, {7'd0, rs});
    check({tag, ".fall"}, {7'd0, fall}, {7'd0, fl});
  endtask

  initial begin
    rst    = 1'b0;
    raw_in = 1'b0;

    // 1. Reset hold with toggling input
    for (int i = 0; i < 3; i++) begin
      raw_in = ~raw_in;
      tick();
      check_outs("reset_hold", 1'b0, 1'b0, 1'b0);
      check("reset_hold.glitch", glitch_cnt, 8'd0);
    end
    raw_in = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    check_outs("post_reset", 1'b0, 1'b0, 1'b0);

    // 2. Clean rise: accepted after edge 6
    raw_in = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_outs("rise_wait", 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_outs("rise_edge6", 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("rise_edge7", 1'b1, 1'b0, 1'b0);

    // 4. Clean fall from IDLE_HIGH
    raw_in = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_outs("fall_wait", 1'b1, 1'b0, 1'b0);
    end
    tick();
    check_outs("fall_edge6", 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("fall_edge7", 1'b0, 1'b0, 1'b0);
    check("fall.glitch", glitch_cnt, 8'd0);

    // 3. Bounce: high 2, low 1, then high; abort at edge 5, accept at edge 9
    raw_in = 1'b1;
    tick();
    tick();
    raw_in = 1'b0;
    tick();
    raw_in = 1'b1;
    for (int e = 4; e <= 8; e++) begin
      tick();
      check_outs("bounce_wait", 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_outs("bounce_edge9", 1'b1, 1'b1, 1'b0);
    check("bounce.glitch", glitch_cnt, GlitchEn ? 8'd1 : 8'd0);
    raw_in = 1'b0;
    for (int e = 1; e <= 8; e++) tick();
    check_outs("bounce_settle", 1'b0, 1'b0, 1'b0);

    // 5. Reset in the middle of a rise qualification
    raw_in = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    check_outs("mid_pre", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #0.5;
    check("mid_async.glitch", glitch_cnt, 8'd0);
    tick();
    tick();
    check_outs("mid_held", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_outs("mid_requal", 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_outs("mid_edge6", 1'b1, 1'b1, 1'b0);
    check("mid.glitch", glitch_cnt, 8'd0);
    raw_in = 1'b0;
    for (int e = 1; e <= 8; e++) tick();
    check_outs("mid_settle", 1'b0, 1'b0, 1'b0);
    check("mid_settle.glitch", glitch_cnt, 8'd0);

    // 6. 260 aborted rise attempts
    for (int a = 1; a <= 260; a++) begin
      raw_in = 1'b1;
      tick();
      raw_in = 1'b0;
      for (int c = 0; c < 5; c++) begin
        tick();
        check("sat.level", {7'd0, level}, 8'd0);
      end
      check("sat.rise", {7'd0, rise}, 8'd0);
      if (a == 100) check("sat.glitch100", glitch_cnt, GlitchEn ? 8'd100 : 8'd0);
      if (a == 255) check("sat.glitch255", glitch_cnt, GlitchEn ? 8'd255 : 8'd0);
    end
    check("sat.glitch_final", glitch_cnt, GlitchEn ? 8'd255 : 8'd0);
    check("sat.level_final", {7'd0, level}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
